// File: rtl/operate_pkg.sv
// operate_pkg
// Shared definitions for the LC-3b operate-instruction issue path: the
// instruction opcodes, the ALU operation codes (the same encoding the ALU
// and its input mux use), the sequencer state encoding, and a decode
// helper that turns an instruction word plus its second register operand
// into the ALU controls.
package operate_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHF = 4'b1101;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_AND   = 3'd1,
        ALU_NOT   = 3'd2,
        ALU_XOR   = 3'd3,
        ALU_LSHF  = 3'd4,
        ALU_RSHFL = 3'd5,
        ALU_RSHFA = 3'd6,
        ALU_ZERO  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic        supported;
        alu_op_t     op;
        logic [15:0] in2;
        logic [3:0]  shift;
    } decode_t;

    // Anything that is not a recognised operate encoding comes back with
    // supported=0 and the ALU told to produce zero.
    function automatic decode_t decode(input logic [15:0] ir, input logic [15:0] opb);
        decode_t     d;
        logic [15:0] imm5;
        logic [15:0] src2;
        imm5        = {{11{ir[4]}}, ir[4:0]};
        src2        = ir[5] ? imm5 : opb;
        d.supported = 1'b0;
        d.op        = ALU_ZERO;
        d.in2       = 16'h0000;
        d.shift     = 4'h0;
        case (ir[15:12])
            OP_ADD: begin
                d.supported = 1'b1;
                d.op        = ALU_ADD;
                d.in2       = src2;
            end
            OP_AND: begin
                d.supported = 1'b1;
                d.op        = ALU_AND;
                d.in2       = src2;
            end
            OP_XOR: begin
                // XOR with immediate all-ones is the NOT encoding.
                d.supported = 1'b1;
                d.in2       = src2;
                d.op        = (ir[5] && (ir[4:0] == 5'b11111)) ? ALU_NOT : ALU_XOR;
            end
            OP_SHF: begin
                d.shift = ir[3:0];
                case (ir[5:4])
                    2'b00: begin
                        d.supported = 1'b1;
                        d.op        = ALU_LSHF;
                    end
                    2'b01: begin
                        d.supported = 1'b1;
                        d.op        = ALU_RSHFL;
                    end
                    2'b11: begin
                        d.supported = 1'b1;
                        d.op        = ALU_RSHFA;
                    end
                    default: begin
                        d.supported = 1'b0;
                        d.op        = ALU_ZERO;
                    end
                endcase
            end
            default: begin
                d.supported = 1'b0;
                d.op        = ALU_ZERO;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/operate_issue_cc_gen.sv
// cc_gen
// Combinational N/Z/P condition-code generator for a 16-bit value.
// Ports:
//   value  in  16  value being written to a register
//   n      out  1  value is negative
//   z      out  1  value is zero
//   p      out  1  value is strictly positive
module cc_gen
    import operate_pkg::*;
(
    input  logic [15:0] value,
    output logic        n,
    output logic        z,
    output logic        p
);

    always_comb begin
        n = value[15];
        z = (value == 16'h0000);
        p = ~value[15] & (value != 16'h0000);
    end

endmodule

// File: rtl/operate_issue.sv
// operate_issue
// Four-cycle issue/write-back sequencer for LC-3b operate instructions
// (ADD, AND, XOR/NOT, SHF). One instruction is accepted in IDLE, its
// operands are read in READ, the ALU is driven in EXEC and the result is
// written back with condition codes in WB.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   inst_valid/ready/inst instruction handshake (ready only in IDLE)
//   rf_raddr1/2, rf_rdata1/2  register-file read port (combinational data)
//   alu_in1/in2/op/shift  ALU controls, live in EXEC, held otherwise
//   alu_out               ALU result
//   rf_we/waddr/wdata     register-file write port, pulsed in WB
//   cc_n/z/p              condition codes
//   done, err             retire pulses for supported / unsupported
module operate_issue
    import operate_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [15:0] inst,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    input  logic [15:0] rf_rdata1,
    input  logic [15:0] rf_rdata2,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [2:0]  alu_op,
    output logic [3:0]  alu_shift,
    input  logic [15:0] alu_out,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        cc_n,
    output logic        cc_z,
    output logic        cc_p,
    output logic        done,
    output logic        err
);

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [15:0] res;
    decode_t     dec;

    logic [15:0] hold_in1;
    logic [15:0] hold_in2;
    logic [2:0]  hold_op;
    logic [3:0]  hold_shift;

    logic        gen_n;
    logic        gen_z;
    logic        gen_p;

    // ir is stable from READ through WB, so the decode is valid in EXEC
    // and still valid in WB for the supported/unsupported split.
    assign dec = decode(ir, opb);

    assign rf_raddr1 = ir[8:6];
    assign rf_raddr2 = ir[2:0];
    assign rf_waddr  = ir[11:9];
    assign rf_wdata  = res;

    // alu_out is exactly the value captured into res at the end of EXEC,
    // so flags computed from it here are the flags of res, available in
    // the WB cycle itself.
    cc_gen u_cc_gen (
        .value (alu_out),
        .n     (gen_n),
        .z     (gen_z),
        .p     (gen_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (inst_valid) state_next = ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        inst_ready = (state == ST_IDLE);
        rf_we      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        alu_in1    = hold_in1;
        alu_in2    = hold_in2;
        alu_op     = hold_op;
        alu_shift  = hold_shift;
        case (state)
            ST_EXEC: begin
                alu_in1   = opa;
                alu_in2   = dec.in2;
                alu_op    = dec.op;
                alu_shift = dec.shift;
            end
            ST_WB: begin
                rf_we = dec.supported;
                done  = dec.supported;
                err   = ~dec.supported;
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

    // Datapath capture: instruction on accept, operands in READ, result
    // and the ALU controls (for holding outside EXEC) in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir         <= 16'h0000;
            opa        <= 16'h0000;
            opb        <= 16'h0000;
            res        <= 16'h0000;
            hold_in1   <= 16'h0000;
            hold_in2   <= 16'h0000;
            hold_op    <= 3'd0;
            hold_shift <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inst_valid) ir <= inst;
                end
                ST_READ: begin
                    opa <= rf_rdata1;
                    opb <= rf_rdata2;
                end
                ST_EXEC: begin
                    res        <= alu_out;
                    hold_in1   <= opa;
                    hold_in2   <= dec.in2;
                    hold_op    <= dec.op;
                    hold_shift <= dec.shift;
                end
                default: begin
                    res <= res;
                end
            endcase
        end
    end

    // Condition codes change only for a supported instruction, on the edge
    // that enters WB; a reset in the middle of an instruction restores Z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_n <= 1'b0;
            cc_z <= 1'b1;
            cc_p <= 1'b0;
        end else if ((state == ST_EXEC) && dec.supported) begin
            cc_n <= gen_n;
            cc_z <= gen_z;
            cc_p <= gen_p;
        end
    end

endmodule

// File: tb/tb_operate_issue.sv
// tb_operate_issue
// Bench for operate_issue: a behavioural register file and ALU around the
// DUT, a transaction-level model that predicts each instruction's ALU
// controls, result, condition codes and retire timing, a per-cycle compare
// process, and directed instructions with hand-computed expectations.
module tb_operate_issue;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [2:0]  rf_raddr1;
    logic [2:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [2:0]  alu_op;
    logic [3:0]  alu_shift;
    logic [15:0] alu_out;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        cc_n;
    logic        cc_z;
    logic        cc_p;
    logic        done;
    logic        err;

    operate_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_shift  (alu_shift),
        .alu_out    (alu_out),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .cc_n       (cc_n),
        .cc_z       (cc_z),
        .cc_p       (cc_p),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file contents are set by the stimulus only; write-back is
    // checked on the write port rather than by updating this array.
    logic [15:0] regs [8];
    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op, input logic [3:0] sh);
        case (op)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return ~a;
            3'd3: return a ^ b;
            3'd4: return a << sh;
            3'd5: return a >> sh;
            3'd6: return 16'($signed(a) >>> sh);
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_out = alu_model(alu_in1, alu_in2, alu_op, alu_shift);

    typedef struct packed {
        logic        sup;
        logic        chk_in2;
        logic [2:0]  op;
        logic [15:0] in1;
        logic [15:0] in2;
        logic [3:0]  sh;
        logic [15:0] res;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  dr;
    } txn_t;

    // What an instruction must do, worked out from the ISA meaning of
    // each encoding with plain arithmetic.
    function automatic txn_t predict(input logic [15:0] i, input logic [15:0] ra, input logic [15:0] rb);
        txn_t        t;
        logic [15:0] b;
        b         = i[5] ? {{11{i[4]}}, i[4:0]} : rb;
        t         = '0;
        t.in1     = ra;
        t.sr1     = i[8:6];
        t.sr2     = i[2:0];
        t.dr      = i[11:9];
        t.op      = 3'd7;
        t.sup     = 1'b1;
        t.chk_in2 = 1'b1;
        t.in2     = b;
        case (i[15:12])
            4'h1: begin t.op = 3'd0; t.res = ra + b; end
            4'h5: begin t.op = 3'd1; t.res = ra & b; end
            4'h9: begin
                if (i[5:0] == 6'h3f) begin t.op = 3'd2; t.res = ~ra; end
                else begin t.op = 3'd3; t.res = ra ^ b; end
            end
            4'hD: begin
                t.in2 = 16'h0000;
                t.sh  = i[3:0];
                case (i[5:4])
                    2'b00: begin t.op = 3'd4; t.res = ra << t.sh; end
                    2'b01: begin t.op = 3'd5; t.res = ra >> t.sh; end
                    2'b11: begin t.op = 3'd6; t.res = 16'($signed(ra) >>> t.sh); end
                    default: t.sup = 1'b0;
                endcase
            end
            default: begin
                t.sup     = 1'b0;
                t.chk_in2 = 1'b0;
            end
        endcase
        return t;
    endfunction

    function automatic logic [2:0] nzp(input logic [15:0] v);
        return {v[15], v == 16'h0000, !v[15] && v != 16'h0000};
    endfunction

    // Model timeline: m_cyc counts clock edges, acc is the edge on which
    // the current instruction was accepted; it retires two edges later
    // and the port is free again from the third.
    int          m_cyc;
    int          acc;
    logic        have;
    txn_t        cur;
    logic [2:0]  exp_cc;
    int          phase;
    logic        m_ready;

    always_comb begin
        phase   = m_cyc - acc;
        m_ready = !have || (phase >= 3);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc  <= 0;
            acc    <= 0;
            have   <= 1'b0;
            cur    <= '0;
            exp_cc <= 3'b010;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_ready && inst_valid) begin
                have <= 1'b1;
                acc  <= m_cyc + 1;
                cur  <= predict(inst, regs[inst[8:6]], regs[inst[2:0]]);
            end
            if (have && (m_cyc + 1 - acc) == 2 && cur.sup) exp_cc <= nzp(cur.res);
        end
    end

    // Hand-computed expectations for the instruction currently offered.
    logic        lit_en;
    logic [2:0]  lit_op;
    logic [15:0] lit_in2;
    logic [15:0] lit_wdata;
    logic [2:0]  lit_cc;
    logic        lit_err;
    logic        timeout_flag;

    int n_checks;
    int n_fail;

    task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("reset inst_ready", 16'(inst_ready), 16'h1);
                checkOutput("reset rf_we", 16'(rf_we), 16'h0);
                checkOutput("reset done", 16'(done), 16'h0);
                checkOutput("reset err", 16'(err), 16'h0);
                checkOutput("reset cc", 16'({cc_n, cc_z, cc_p}), 16'h2);
            end else begin
                checkOutput("watchdog", 16'(timeout_flag), 16'h0);
                checkOutput("inst_ready", 16'(inst_ready), 16'(m_ready));
                checkOutput("rf_we", 16'(rf_we), 16'(have && phase == 2 && cur.sup));
                checkOutput("done", 16'(done), 16'(have && phase == 2 && cur.sup));
                checkOutput("err", 16'(err), 16'(have && phase == 2 && !cur.sup));
                checkOutput("cc", 16'({cc_n, cc_z, cc_p}), 16'(exp_cc));
                if (have && phase == 0) begin
                    checkOutput("rf_raddr1", 16'(rf_raddr1), 16'(cur.sr1));
                    checkOutput("rf_raddr2", 16'(rf_raddr2), 16'(cur.sr2));
                end
                if (have && phase == 1) begin
                    checkOutput("alu_op", 16'(alu_op), 16'(cur.op));
                    checkOutput("alu_in1", alu_in1, cur.in1);
                    checkOutput("alu_shift", 16'(alu_shift), 16'(cur.sh));
                    if (cur.chk_in2) checkOutput("alu_in2", alu_in2, cur.in2);
                    if (lit_en) begin
                        checkOutput("literal alu_op", 16'(alu_op), 16'(lit_op));
                        if (cur.chk_in2) checkOutput("literal alu_in2", alu_in2, lit_in2);
                    end
                end
                if (have && phase == 2) begin
                    if (cur.sup) begin
                        checkOutput("rf_waddr", 16'(rf_waddr), 16'(cur.dr));
                        checkOutput("rf_wdata", rf_wdata, cur.res);
                        if (lit_en) checkOutput("literal rf_wdata", rf_wdata, lit_wdata);
                    end
                    if (lit_en) begin
                        checkOutput("literal cc", 16'({cc_n, cc_z, cc_p}), 16'(lit_cc));
                        checkOutput("literal err", 16'(err), 16'(lit_err));
                    end
                end
            end
        end
    end

    // Offer one instruction, wait (bounded) for it to be accepted and then
    // for its retire pulse.
    task automatic applyStimulus(input logic [15:0] i, input logic [2:0] op, input logic [15:0] in2,
                                 input logic [15:0] wdata, input logic [2:0] cc, input logic e);
        bit got;
        @(negedge clk);
        #1;
        inst       = i;
        inst_valid = 1'b1;
        lit_en     = 1'b1;
        lit_op     = op;
        lit_in2    = in2;
        lit_wdata  = wdata;
        lit_cc     = cc;
        lit_err    = e;
        got        = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (inst_ready) got = 1'b1;
            @(posedge clk);
        end
        if (!got) timeout_flag = 1'b1;
        #1 inst_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (done || err) got = 1'b1;
        end
        if (!got) timeout_flag = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        inst_valid   = 1'b0;
        inst         = 16'h0000;
        lit_en       = 1'b0;
        lit_op       = 3'd0;
        lit_in2      = 16'h0000;
        lit_wdata    = 16'h0000;
        lit_cc       = 3'b010;
        lit_err      = 1'b0;
        timeout_flag = 1'b0;
        for (int r = 0; r < 8; r++) regs[r] = 16'h0000;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] ADD register");
        regs[1] = 16'h0005;
        regs[2] = 16'hFFFB;
        applyStimulus(16'h1642, 3'd0, 16'hFFFB, 16'h0000, 3'b010, 1'b0);

        $display("[TB] AND immediate");
        regs[1] = 16'h00F3;
        applyStimulus(16'h567F, 3'd1, 16'hFFFF, 16'h00F3, 3'b001, 1'b0);

        $display("[TB] NOT and XOR");
        regs[1] = 16'h8000;
        applyStimulus(16'h967F, 3'd2, 16'hFFFF, 16'h7FFF, 3'b001, 1'b0);
        applyStimulus(16'h9661, 3'd3, 16'h0001, 16'h8001, 3'b100, 1'b0);

        $display("[TB] shifts");
        regs[1] = 16'h8004;
        applyStimulus(16'hD672, 3'd6, 16'h0000, 16'hE001, 3'b100, 1'b0);
        applyStimulus(16'hD662, 3'd7, 16'h0000, 16'h0000, 3'b100, 1'b1);

        $display("[TB] illegal opcode");
        applyStimulus(16'h0000, 3'd7, 16'h0000, 16'h0000, 3'b100, 1'b1);

        $display("[TB] valid held through busy cycles");
        lit_op    = 3'd0;
        lit_in2   = 16'h0002;
        lit_wdata = 16'h8006;
        lit_cc    = 3'b100;
        lit_err   = 1'b0;
        @(negedge clk);
        #1;
        inst       = 16'h1262;
        inst_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 inst_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] reset during EXEC");
        lit_en = 1'b0;
        @(negedge clk);
        #1;
        inst       = 16'h1262;
        inst_valid = 1'b1;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] recovery after reset");
        regs[1] = 16'h00F3;
        applyStimulus(16'h567F, 3'd1, 16'hFFFF, 16'h00F3, 3'b001, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
